// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the data/byte-enable widths and the
// misalignment check used by the responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A word access is misaligned when the low address bits are non-zero and
  // at least one byte lane is enabled.
  function automatic logic is_misaligned(input logic [31:0]     addr,
                                         input logic [BE_W-1:0] be);
    return (addr[1:0] != 2'b00) && (|be);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for the data-memory responder.
// DEPTH words of WORD_W bits, cleared by the asynchronous active-low reset,
// one byte-enabled write port and one combinational read port sharing the
// same word index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Clear every word on reset; otherwise merge the enabled byte lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port.
// Accepts one load/store at a time over valid/ready, waits WAIT_CYCLES
// extra cycles, performs the access on the transition into RESP and holds
// the response until the requester takes it.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- when defined, byte
// addresses at or beyond DEPTH*4 report rsp_err and suppress stores; when
// undefined the word index simply wraps modulo DEPTH.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              accept;
  logic              go_resp;
  logic              op_we;
  logic [31:0]       op_addr;
  logic [WORD_W-1:0] op_wdata;
  logic [BE_W-1:0]   op_be;
  logic [IDX_W-1:0]  op_idx;
  logic              op_oor;
  logic              op_err;
  logic              wr_en;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] resp_data;

  assign accept = req_valid && req_ready;

  // With zero wait cycles the access happens on the accept edge itself, so
  // the operation fields come straight from the request port in IDLE.
  always_comb begin
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_be    = be_q;
    if (state == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end
  end

  // Flag the edge on which the FSM enters RESP and the access is performed.
  always_comb begin
    go_resp = 1'b0;
    case (state)
      IDLE:    go_resp = accept && (WAIT_CYCLES == 0);
      WAIT:    go_resp = (wait_cnt == CNT_LAST);
      default: go_resp = 1'b0;
    endcase
  end

  assign op_idx = op_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign op_oor = (op_addr >> (IDX_W + 2)) != 32'd0;
`else
  assign op_oor = 1'b0;
`endif

  assign op_err    = is_misaligned(op_addr, op_be) || op_oor;
  assign wr_en     = go_resp && op_we && !op_err;
  assign resp_data = (!op_we && !op_err) ? rd_data : '0;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .idx     (op_idx),
    .wr_data (op_wdata),
    .wr_be   (op_be),
    .rd_data (rd_data)
  );

  // Request latch, wait counter and registered handshake/response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            req_ready <= 1'b0;
            wait_cnt  <= 4'd0;
            if (go_resp) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= op_err;
              rsp_rdata <= resp_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (go_resp) begin
            state     <= RESP;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_err   <= op_err;
            rsp_rdata <= resp_data;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=64, WAIT_CYCLES=1).
// Expected responses are queued when a request is accepted and compared
// when the responder hands a response over. Honours DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 1;
  localparam int IDX_W       = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle_cnt = 0;
  int          accept_cycle = 0;
  int          rsp_cycle = 0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always @(posedge clk) cycle_cnt++;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Expected response of the reference model for one request.
  function automatic exp_t model_expect(input logic we, input logic [31:0] addr, input logic [3:0] be);
    exp_t e;
    logic oor;
    oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (addr >= 32'(DEPTH * 4));
`endif
    e.err   = ((addr[1:0] != 2'b00) && (be != 4'h0)) || oor;
    e.rdata = (!we && !e.err) ? model_mem[addr[IDX_W+1:2]] : 32'h0;
    return e;
  endfunction

  // Scoreboard: compare every response handed over against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (rsp_valid && !prev_valid) rsp_cycle = cycle_cnt;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("rsp_rdata", rsp_rdata, e.rdata);
          check_output("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Drive one request, wait for acceptance, queue its expected response.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      check_output("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    accept_cycle = cycle_cnt;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[addr[IDX_W+1:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic apply_model(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e = model_expect(we, addr, be);
    apply_stimulus(we, addr, wdata, be, e.rdata, e.err);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string phase);
    check_output({phase, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check_output({phase, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_output({phase, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_output({phase, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    #12;
    check_reset_outputs("por");
    reset = 1'b1;

    // Reset mid-WAIT drops the request and clears memory.
    apply_stimulus(1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1'b0);
    wait_drain();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    @(negedge clk);
    check_output("t1_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_output("t1_busy_ready", {31'd0, req_ready}, 32'd0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midwait");
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    @(posedge clk); #3 reset = 1'b1;
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_drain();

    // Store then load, with latency check.
    apply_stimulus(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    wait_drain();
    apply_stimulus(1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    wait_drain();
    check_output("load_latency", 32'(rsp_cycle - accept_cycle), 32'(WAIT_CYCLES + 1));

    // Byte enables.
    apply_stimulus(1'b1, 32'h4, 32'h11223344, 4'hF, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'h4, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    wait_drain();

    // Misaligned store is rejected; misaligned load errors; be=0 store is a no-op.
    apply_stimulus(1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    apply_stimulus(1'b0, 32'h4, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
    apply_stimulus(1'b0, 32'h9, 32'h0, 4'hF, 32'h0, 1'b1);
    apply_stimulus(1'b1, 32'h8, 32'h55555555, 4'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    wait_drain();

    // Backpressure: response held, second request not accepted.
    rsp_ready = 1'b0;
    apply_stimulus(1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'h77777777; req_be = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check_output("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_output("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check_output("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      check_output("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);
    apply_stimulus(1'b0, 32'hC, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_drain();

    // Out-of-range address.
    apply_stimulus(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
    apply_stimulus(1'b0, 32'h100, 32'h0, 4'hF, 32'h0, 1'b1);
`else
    apply_stimulus(1'b0, 32'h100, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
`endif
    wait_drain();

    // Random mixed traffic against the reference model.
    for (int n = 0; n < 24; n++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      if ($urandom_range(0, 5) == 0) a = a + 32'd2;
      apply_model(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
